goe_tx: RTL and testbench
=========================

// Module: goe_tx
// PURPOSE
//  Output engine directly downstream of the packet-generator stage. Buffers 134-bit packet words and
//  1024-bit PHVs, pairs each complete packet with its PHV, then forwards or drops it per the drop bit
//  and valid tag. Counts sent/dropped packets; passes the configuration channel through one register.
// PARAMETERS
//  LMID        8'd7  own module ID (config pass-through tag, informational)
//  DAW         8     data FIFO address width (256 x 134)
//  PAW         4     PHV/tag FIFO address width (16 entries each)
//  ALF_MARGIN  128   data FIFO free words at/below which out_goe_alf asserts
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     synchronous active-low reset
//  in_goe_data      in   134   [133:132] 01 head/11 body/10 tail, [131:128] invalid bytes, [127:0] data
//  in_goe_data_wr   in   1     data word strobe
//  in_goe_valid     in   1     packet keep(1)/discard(0); sampled with in_goe_valid_wr
//  in_goe_valid_wr  in   1     one pulse per packet, on or after its tail word
//  in_goe_phv       in   1024  PHV; bit 1023 = DROP
//  in_goe_phv_wr    in   1     PHV strobe, one per packet
//  out_goe_alf      out  1     almost-full to upstream (data or PHV side)
//  out_goe_phv_alf  out  1     PHV FIFO almost-full (free entries <= 2)
//  out_goe_data     out  134   packet word to port
//  out_goe_data_wr  out  1     word strobe
//  out_goe_valid    out  1     always 1 when out_goe_valid_wr
//  out_goe_valid_wr out  1     pulses with the tail word of each forwarded packet
//  in_goe_alf       in   1     downstream almost-full
//  cin_goe_data     in   134   config packet word
//  cin_goe_data_wr  in   1     config strobe
//  cout_goe_ready   out  1     = cin_goe_ready (combinational)
//  cout_goe_data    out  134   config word, 1-cycle registered copy
//  cout_goe_data_wr out  1     registered copy of cin_goe_data_wr
//  cin_goe_ready    in   1     downstream config ready
//  goe_sent_cnt     out  32    forwarded packets, wraps 2^32-1 -> 0
//  goe_drop_cnt     out  32    dropped packets, wraps
// BEHAVIOUR
//  Reset: all outputs 0, FIFOs empty, FSM IDLE, counters 0; reset mid-packet discards all buffered state.
//  Write side: every in_goe_data_wr writes the data FIFO; in_goe_valid_wr pushes in_goe_valid into tag
//   FIFO; in_goe_phv_wr pushes PHV FIFO. Writes to a full FIFO are dropped (upstream error; no stall).
//  out_goe_alf = (data free <= ALF_MARGIN) | (tag free <= 2) | (PHV free <= 2), registered.
//  FSM: IDLE -> when tag FIFO and PHV FIFO both non-empty: pop tag and PHV (1 cycle), go DECIDE.
//   DECIDE: drop = ~tag | phv[1023]. drop -> DROP; else if ~in_goe_alf -> SEND; else stay DECIDE.
//   SEND: pop one data word per cycle, drive out_goe_data/out_goe_data_wr next cycle (RAM read
//    latency 1); in_goe_alf is NOT rechecked mid-packet. Tail word (10) -> out_goe_valid_wr=1,
//    out_goe_valid=1, goe_sent_cnt+1, -> IDLE.
//   DROP: pop one word per cycle, no output; on tail goe_drop_cnt+1 -> IDLE.
//  Single-word packet (flag 10 only, or head with flag 10 handling) treated as tail on first word.
//  Data FIFO empty in SEND/DROP (tag arrived before tail): pause, resume when words arrive.
//  Throughput: 1 word/cycle in SEND; 2 idle cycles between packets (pop + decide).
//  PHV is consumed only for the decision; out PHV not forwarded. Simultaneous push/pop on any FIFO
//   is legal at any occupancy including full and empty.
//  Config path independent of FSM; latency exactly 1 cycle, no buffering.
// TESTING
//  3-word pkt, valid=1, phv[1023]=0, in_goe_alf=0 -> 3 out words, valid_wr on 3rd, sent_cnt=1.
//  Same pkt with phv[1023]=1 -> no out_goe_data_wr, drop_cnt=1; next kept pkt forwarded intact.
//  in_goe_alf=1 held 20 cycles at DECIDE -> no output; release -> pkt starts within 2 cycles.
//  Write 128+ words without tag -> out_goe_alf=1; send tags -> drains, alf deasserts.
//  Assert rst_n=0 mid-SEND -> all outputs 0 next cycle, counters 0, next pkt clean.
//  cin word 0x...A5 with wr=1 -> cout same word, wr=1 one cycle later; ready follows cin_goe_ready.

Source files
------------

// File: rtl/goe_tx.sv
// Output engine: buffers packet words, tags and PHV drop bits, pairs each packet with its
// verdict, then forwards or discards it; config channel passes through one register stage.
module goe_tx #(
    parameter logic [7:0] LMID       = 8'd7,
    parameter int         DAW        = 8,
    parameter int         PAW        = 4,
    parameter int         ALF_MARGIN = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [133:0]   in_goe_data,
    input  logic           in_goe_data_wr,
    input  logic           in_goe_valid,
    input  logic           in_goe_valid_wr,
    input  logic [1023:0]  in_goe_phv,
    input  logic           in_goe_phv_wr,
    output logic           out_goe_alf,
    output logic           out_goe_phv_alf,
    output logic [133:0]   out_goe_data,
    output logic           out_goe_data_wr,
    output logic           out_goe_valid,
    output logic           out_goe_valid_wr,
    input  logic           in_goe_alf,
    input  logic [133:0]   cin_goe_data,
    input  logic           cin_goe_data_wr,
    output logic           cout_goe_ready,
    output logic [133:0]   cout_goe_data,
    output logic           cout_goe_data_wr,
    input  logic           cin_goe_ready,
    output logic [31:0]    goe_sent_cnt,
    output logic [31:0]    goe_drop_cnt
);
    localparam int DD = 1 << DAW;
    localparam int PD = 1 << PAW;

    typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_SEND, S_DROP} state_t;

    // Only the DROP bit of each PHV affects behaviour, so only that bit is buffered.
    logic unused_ok;
    assign unused_ok = ^{in_goe_phv[1022:0], LMID};

    logic [133:0] dmem [DD];
    logic         tmem [PD];
    logic         pmem [PD];

    logic [DAW:0] dwr_q, drd_q, dcnt, dfree;
    logic [PAW:0] twr_q, trd_q, tcnt, tfree;
    logic [PAW:0] pwr_q, prd_q, pcnt, pfree;
    logic         d_push, d_pop, t_push, p_push, tp_pop;
    logic         dempty, tempty, pempty, d_tail;
    logic [133:0] d_head;

    state_t       state_q, state_d;
    logic         drop_q, drop_d;
    logic         out_wr_d, vwr_d, dinc_d;

    logic [133:0] out_data_q, cdata_q;
    logic         out_wr_q, vwr_q, cwr_q, alf_q, phv_alf_q;
    logic [31:0]  sent_q, dropc_q;

    assign dcnt   = dwr_q - drd_q;
    assign tcnt   = twr_q - trd_q;
    assign pcnt   = pwr_q - prd_q;
    assign dfree  = (DAW+1)'(DD) - dcnt;
    assign tfree  = (PAW+1)'(PD) - tcnt;
    assign pfree  = (PAW+1)'(PD) - pcnt;
    assign dempty = (dcnt == '0);
    assign tempty = (tcnt == '0);
    assign pempty = (pcnt == '0);

    // A full FIFO still accepts a write in the same cycle one entry leaves.
    assign d_push = in_goe_data_wr  & (~dcnt[DAW] | d_pop);
    assign t_push = in_goe_valid_wr & (~tcnt[PAW] | tp_pop);
    assign p_push = in_goe_phv_wr   & (~pcnt[PAW] | tp_pop);

    assign d_head = dmem[drd_q[DAW-1:0]];
    assign d_tail = (d_head[133:132] == 2'b10);

    always_ff @(posedge clk) begin
        if (d_push) dmem[dwr_q[DAW-1:0]] <= in_goe_data;
        if (t_push) tmem[twr_q[PAW-1:0]] <= in_goe_valid;
        if (p_push) pmem[pwr_q[PAW-1:0]] <= in_goe_phv[1023];
    end

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        tp_pop   = 1'b0;
        d_pop    = 1'b0;
        out_wr_d = 1'b0;
        vwr_d    = 1'b0;
        dinc_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tempty && !pempty) begin
                    tp_pop  = 1'b1;
                    drop_d  = ~tmem[trd_q[PAW-1:0]] | pmem[prd_q[PAW-1:0]];
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (drop_q)           state_d = S_DROP;
                else if (!in_goe_alf) state_d = S_SEND;
            end
            S_SEND: begin
                if (!dempty) begin
                    d_pop    = 1'b1;
                    out_wr_d = 1'b1;
                    if (d_tail) begin
                        vwr_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (!dempty) begin
                    d_pop = 1'b1;
                    if (d_tail) begin
                        dinc_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            drop_q     <= 1'b0;
            dwr_q      <= '0;
            drd_q      <= '0;
            twr_q      <= '0;
            trd_q      <= '0;
            pwr_q      <= '0;
            prd_q      <= '0;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
            vwr_q      <= 1'b0;
            sent_q     <= '0;
            dropc_q    <= '0;
            alf_q      <= 1'b0;
            phv_alf_q  <= 1'b0;
            cdata_q    <= '0;
            cwr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (d_push) dwr_q <= dwr_q + (DAW+1)'(1);
            if (d_pop)  drd_q <= drd_q + (DAW+1)'(1);
            if (t_push) twr_q <= twr_q + (PAW+1)'(1);
            if (p_push) pwr_q <= pwr_q + (PAW+1)'(1);
            if (tp_pop) begin
                trd_q <= trd_q + (PAW+1)'(1);
                prd_q <= prd_q + (PAW+1)'(1);
            end
            // Output stage: word read at pop time appears one cycle later.
            if (out_wr_d) out_data_q <= d_head;
            out_wr_q <= out_wr_d;
            vwr_q    <= vwr_d;
            if (vwr_d)  sent_q  <= sent_q + 32'd1;
            if (dinc_d) dropc_q <= dropc_q + 32'd1;
            alf_q     <= (dfree <= (DAW+1)'(ALF_MARGIN)) | (tfree <= (PAW+1)'(2)) |
                         (pfree <= (PAW+1)'(2));
            phv_alf_q <= (pfree <= (PAW+1)'(2));
            cdata_q   <= cin_goe_data;
            cwr_q     <= cin_goe_data_wr;
        end
    end

    assign out_goe_data     = out_data_q;
    assign out_goe_data_wr  = out_wr_q;
    assign out_goe_valid    = vwr_q;
    assign out_goe_valid_wr = vwr_q;
    assign out_goe_alf      = alf_q;
    assign out_goe_phv_alf  = phv_alf_q;
    assign goe_sent_cnt     = sent_q;
    assign goe_drop_cnt     = dropc_q;
    assign cout_goe_ready   = cin_goe_ready;
    assign cout_goe_data    = cdata_q;
    assign cout_goe_data_wr = cwr_q;

endmodule

// File: tb/tb_goe_tx.sv
// Bench for goe_tx: packet-level model of forwarded words and counters, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_goe_tx;
    logic           clk = 1'b0;
    logic           rst_n;
    logic [133:0]   in_goe_data;
    logic           in_goe_data_wr, in_goe_valid, in_goe_valid_wr;
    logic [1023:0]  in_goe_phv;
    logic           in_goe_phv_wr;
    logic           out_goe_alf, out_goe_phv_alf;
    logic [133:0]   out_goe_data;
    logic           out_goe_data_wr, out_goe_valid, out_goe_valid_wr;
    logic           in_goe_alf;
    logic [133:0]   cin_goe_data;
    logic           cin_goe_data_wr;
    logic           cout_goe_ready;
    logic [133:0]   cout_goe_data;
    logic           cout_goe_data_wr;
    logic           cin_goe_ready;
    logic [31:0]    goe_sent_cnt, goe_drop_cnt;

    goe_tx dut (
        .clk(clk), .rst_n(rst_n),
        .in_goe_data(in_goe_data), .in_goe_data_wr(in_goe_data_wr),
        .in_goe_valid(in_goe_valid), .in_goe_valid_wr(in_goe_valid_wr),
        .in_goe_phv(in_goe_phv), .in_goe_phv_wr(in_goe_phv_wr),
        .out_goe_alf(out_goe_alf), .out_goe_phv_alf(out_goe_phv_alf),
        .out_goe_data(out_goe_data), .out_goe_data_wr(out_goe_data_wr),
        .out_goe_valid(out_goe_valid), .out_goe_valid_wr(out_goe_valid_wr),
        .in_goe_alf(in_goe_alf),
        .cin_goe_data(cin_goe_data), .cin_goe_data_wr(cin_goe_data_wr),
        .cout_goe_ready(cout_goe_ready), .cout_goe_data(cout_goe_data),
        .cout_goe_data_wr(cout_goe_data_wr), .cin_goe_ready(cin_goe_ready),
        .goe_sent_cnt(goe_sent_cnt), .goe_drop_cnt(goe_drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: words of the packet being written, words expected on the output, counts.
    logic [133:0] pend_q[$];
    logic [133:0] exp_q[$];
    int           exp_drop   = 0;
    int           tails_seen = 0;
    int           words_seen = 0;
    logic [133:0] last_word  = '0;
    bit           chk_en     = 1'b0;

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [133:0] mk(input int i, input int n, input logic [127:0] seed);
        logic [1:0] fl;
        fl = (i == n - 1) ? 2'b10 : ((i == 0) ? 2'b01 : 2'b11);
        return {fl, 4'(i), seed + 128'(i)};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (out_goe_data_wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_goe_data, '0);
                end else begin
                    logic [133:0] w;
                    w = exp_q.pop_front();
                    chk("out_data", out_goe_data, w);
                    chk("valid_wr_on_tail", 134'(out_goe_valid_wr), 134'(w[133:132] == 2'b10));
                    if (w[133:132] == 2'b10) tails_seen++;
                    words_seen++;
                    last_word = out_goe_data;
                end
            end else begin
                chk("valid_wr_without_word", 134'(out_goe_valid_wr), '0);
            end
            if (out_goe_valid_wr) chk("valid_level", 134'(out_goe_valid), 134'(1));
            chk("sent_cnt_track", 134'(goe_sent_cnt), 134'(tails_seen));
        end
    end

    task automatic idle_strobes();
        in_goe_data_wr  = 1'b0;
        in_goe_valid_wr = 1'b0;
        in_goe_phv_wr   = 1'b0;
        in_goe_valid    = 1'b0;
    endtask

    task automatic send_words(input int n, input logic [127:0] seed);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            idle_strobes();
            in_goe_data    = mk(i, n, seed);
            in_goe_data_wr = 1'b1;
            pend_q.push_back(in_goe_data);
        end
        @(posedge clk); #1;
        idle_strobes();
    endtask

    task automatic send_tag(input bit tag, input bit drop);
        logic [1023:0] p;
        for (int k = 0; k < 32; k++) p[k*32 +: 32] = $urandom;
        p[1023] = drop;
        @(posedge clk); #1;
        idle_strobes();
        in_goe_valid    = tag;
        in_goe_valid_wr = 1'b1;
        in_goe_phv      = p;
        in_goe_phv_wr   = 1'b1;
        if (tag && !drop) begin
            foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
        end else begin
            exp_drop++;
        end
        pend_q.delete();
        @(posedge clk); #1;
        idle_strobes();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_left", 134'(exp_q.size()), '0);
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},    out_goe_data, '0);
        chk({tag, "_data_wr"}, 134'(out_goe_data_wr), '0);
        chk({tag, "_valid"},   134'({out_goe_valid, out_goe_valid_wr}), '0);
        chk({tag, "_alf"},     134'({out_goe_alf, out_goe_phv_alf}), '0);
        chk({tag, "_cout"},    cout_goe_data, '0);
        chk({tag, "_cout_wr"}, 134'(cout_goe_data_wr), '0);
        chk({tag, "_sent"},    134'(goe_sent_cnt), '0);
        chk({tag, "_drop"},    134'(goe_drop_cnt), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [133:0] lw, cw;
        int sv;
        rst_n = 1'b0;
        idle_strobes();
        in_goe_data = '0;
        in_goe_phv = '0;
        in_goe_alf = 1'b0;
        cin_goe_data = '0;
        cin_goe_data_wr = 1'b0;
        cin_goe_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        chk("reset_cout_ready", 134'(cout_goe_ready), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Kept 3-word packet.
        send_words(3, 128'h1000);
        send_tag(1'b1, 1'b0);
        drain(50);
        chk("t1_sent", 134'(goe_sent_cnt), 134'(1));
        chk("t1_words", 134'(words_seen), 134'(3));
        lw = {2'b10, 4'd2, 128'h1002};
        chk("t1_tail_word", last_word, lw);

        // Same packet dropped by PHV, then a kept packet, a tag-discarded one, a single-word one.
        send_words(3, 128'h1000);
        send_tag(1'b1, 1'b1);
        repeat (12) @(negedge clk); #1;
        chk("t2_drop", 134'(goe_drop_cnt), 134'(1));
        chk("t2_words", 134'(words_seen), 134'(3));
        send_words(5, 128'h2000);
        send_tag(1'b1, 1'b0);
        send_words(2, 128'h3000);
        send_tag(1'b0, 1'b0);
        send_words(1, 128'h4000);
        send_tag(1'b1, 1'b0);
        drain(100);
        chk("t2_sent", 134'(goe_sent_cnt), 134'(3));
        chk("t2_drop_cnt", 134'(goe_drop_cnt), 134'(exp_drop));
        chk("t2_drop_lit", 134'(goe_drop_cnt), 134'(2));
        chk("t2_words_all", 134'(words_seen), 134'(9));

        // Downstream almost-full held while a packet waits for its decision.
        in_goe_alf = 1'b1;
        send_words(4, 128'h5000);
        send_tag(1'b1, 1'b0);
        sv = words_seen;
        repeat (20) @(negedge clk); #1;
        chk("alf_hold_no_output", 134'(words_seen), 134'(sv));
        @(posedge clk); #1;
        in_goe_alf = 1'b0;
        repeat (3) @(negedge clk); #1;
        chk("alf_release_start", 134'(words_seen), 134'(sv + 1));
        drain(50);
        chk("alf_pkt_words", 134'(words_seen), 134'(sv + 4));

        // Upstream almost-full from data FIFO occupancy.
        send_words(130, 128'h6000);
        @(negedge clk);
        chk("alf_assert", 134'(out_goe_alf), 134'(1));
        chk("phv_alf_idle", 134'(out_goe_phv_alf), '0);
        send_tag(1'b1, 1'b0);
        drain(400);
        chk("alf_deassert", 134'(out_goe_alf), '0);
        chk("big_sent", 134'(goe_sent_cnt), 134'(5));

        // Reset in the middle of sending.
        send_words(10, 128'h7000);
        send_tag(1'b1, 1'b0);
        sv = words_seen;
        for (int i = 0; i < 60 && words_seen < sv + 2; i++) begin
            @(negedge clk); #1;
        end
        chk("mid_send_reached", 134'(words_seen >= sv + 2), 134'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk_en = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("midrst");
        exp_q.delete();
        pend_q.delete();
        tails_seen = 0;
        words_seen = 0;
        exp_drop = 0;
        rst_n = 1'b1;
        chk_en = 1'b1;
        send_words(3, 128'h8000);
        send_tag(1'b1, 1'b0);
        drain(50);
        chk("post_rst_sent", 134'(goe_sent_cnt), 134'(1));
        chk("post_rst_words", 134'(words_seen), 134'(3));
        lw = {2'b10, 4'd2, 128'h8002};
        chk("post_rst_tail", last_word, lw);
        chk("post_rst_drop", 134'(goe_drop_cnt), '0);

        // Config pass-through.
        cw = {2'b11, 4'h3, 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5};
        @(posedge clk); #1;
        cin_goe_data = cw;
        cin_goe_data_wr = 1'b1;
        chk("cfg_wr_not_early", 134'(cout_goe_data_wr), '0);
        @(posedge clk); #1;
        cin_goe_data = '0;
        cin_goe_data_wr = 1'b0;
        chk("cfg_data", cout_goe_data, cw);
        chk("cfg_wr", 134'(cout_goe_data_wr), 134'(1));
        @(posedge clk); #1;
        chk("cfg_wr_drop", 134'(cout_goe_data_wr), '0);
        cin_goe_ready = 1'b1;
        #1;
        chk("cfg_ready_hi", 134'(cout_goe_ready), 134'(1));
        cin_goe_ready = 1'b0;
        #1;
        chk("cfg_ready_lo", 134'(cout_goe_ready), '0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
